// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bus.
// Carries requester handshakes, read returns and the shared memory port.
interface mem_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              req_a;
   logic              req_b;
   logic              we_a;
   logic              we_b;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] wdata_a;
   logic [DATA_W-1:0] wdata_b;
   logic              gnt_a;
   logic              gnt_b;
   logic              rvalid_a;
   logic              rvalid_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;

   modport slave (
      input  req_a, req_b, we_a, we_b,
      input  addr_a, addr_b, wdata_a, wdata_b,
      input  data_out,
      output gnt_a, gnt_b, rvalid_a, rvalid_b,
      output rdata_a, rdata_b,
      output read, write, addr, data_in
   );

   modport master (
      output req_a, req_b, we_a, we_b,
      output addr_a, addr_b, wdata_a, wdata_b,
      output data_out,
      input  gnt_a, gnt_b, rvalid_a, rvalid_b,
      input  rdata_a, rdata_b,
      input  read, write, addr, data_in
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between two requesters.
// Write: IDLE-ACCESS (2 cycles); read: IDLE-ACCESS-RDATA (3 cycles).
module mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input logic          clk,
   input logic          rst_,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RDATA
   } state_e;

   state_e            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              own_q, own_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              gnt_a_q, gnt_a_d;
   logic              gnt_b_q, gnt_b_d;
   logic              rv_a_q, rv_a_d;
   logic              rv_b_q, rv_b_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
   logic              any_req;
   logic              win;

   // win: 0 = A, 1 = B; pointer only breaks ties
   assign any_req = bus.req_a | bus.req_b;
   assign win     = (bus.req_a & bus.req_b) ? ptr_q : bus.req_b;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b0;
         own_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         gnt_a_q   <= 1'b0;
         gnt_b_q   <= 1'b0;
         rv_a_q    <= 1'b0;
         rv_b_q    <= 1'b0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         own_q     <= own_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         gnt_a_q   <= gnt_a_d;
         gnt_b_q   <= gnt_b_d;
         rv_a_q    <= rv_a_d;
         rv_b_q    <= rv_b_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      own_d     = own_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      gnt_a_d   = 1'b0;
      gnt_b_d   = 1'b0;
      rv_a_d    = 1'b0;
      rv_b_d    = 1'b0;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               own_d   = win;
               we_d    = win ? bus.we_b : bus.we_a;
               addr_d  = win ? bus.addr_b : bus.addr_a;
               wdata_d = win ? bus.wdata_b : bus.wdata_a;
               gnt_a_d = ~win;
               gnt_b_d = win;
               ptr_d   = ~win;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = we_q ? IDLE : RDATA;
         end
         RDATA: begin
            // memory registered data_out at the end of ACCESS
            if (own_q) begin
               rdata_b_d = bus.data_out;
               rv_b_d    = 1'b1;
            end else begin
               rdata_a_d = bus.data_out;
               rv_a_d    = 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.gnt_a    = gnt_a_q;
   assign bus.gnt_b    = gnt_b_q;
   assign bus.rvalid_a = rv_a_q;
   assign bus.rvalid_b = rv_b_q;
   assign bus.rdata_a  = rdata_a_q;
   assign bus.rdata_b  = rdata_b_q;
   assign bus.read     = (state_q == ACCESS) & ~we_q;
   assign bus.write    = (state_q == ACCESS) & we_q;
   assign bus.addr     = addr_q;
   assign bus.data_in  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level schedule model.
// Model: accept when free, fixed 2/3-cycle occupancy, round-robin on ties.
module tb_mem_arbiter;

   localparam int AW  = 5;
   localparam int DW  = 8;
   localparam int NC  = 1024;
   localparam int LIM = 300;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } txn_t;

   logic clk = 1'b0;
   logic rst_;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [32] = '{default: '0};

   always @(posedge clk) begin
      if (bus.write) mem[bus.addr] <= bus.data_in;
      if (bus.read) bus.data_out <= mem[bus.addr];
   end

   int            n_tot = 0;
   int            n_bad = 0;
   int            cyc;
   int            free;
   int            ptr;
   bit            rnd;
   logic [5:0]    e_ctl [NC];
   logic [AW-1:0] e_addr [NC];
   logic [DW-1:0] e_din [NC];
   logic [DW-1:0] e_rdat [NC];
   logic [DW-1:0] cur [2];
   logic [DW-1:0] ref_mem [32];
   logic          pend [2];
   logic          dwe [2];
   logic [AW-1:0] dad [2];
   logic [DW-1:0] dwd [2];
   txn_t          tq [2][$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic txn_t mk(input logic we, input int a, input int d);
      return '{we, AW'(a), DW'(d)};
   endfunction

   function automatic logic [63:0] all_out();
      return 64'({bus.gnt_a, bus.gnt_b, bus.read, bus.write,
                  bus.rvalid_a, bus.rvalid_b, bus.rdata_a,
                  bus.rdata_b, bus.addr, bus.data_in});
   endfunction

   task automatic apply();
      bus.req_a   = pend[0];
      bus.we_a    = dwe[0];
      bus.addr_a  = dad[0];
      bus.wdata_a = dwd[0];
      bus.req_b   = pend[1];
      bus.we_b    = dwe[1];
      bus.addr_b  = dad[1];
      bus.wdata_b = dwd[1];
   endtask

   task automatic model_clear();
      for (int i = 0; i < NC; i++) e_ctl[i] = '0;
      for (int r = 0; r < 2; r++) begin
         pend[r] = 1'b0;
         cur[r]  = '0;
         tq[r].delete();
      end
      free = 0;
      ptr  = 0;
      cyc  = 0;
      apply();
   endtask

   // ctl bits: {gnt_a, gnt_b, read, write, rvalid_a, rvalid_b}
   task automatic tick();
      int   w;
      txn_t t;
      @(negedge clk);
      chk("ctl", 64'({bus.gnt_a, bus.gnt_b, bus.read, bus.write,
                      bus.rvalid_a, bus.rvalid_b}), 64'(e_ctl[cyc]));
      if (e_ctl[cyc][3] | e_ctl[cyc][2])
         chk("addr", 64'(bus.addr), 64'(e_addr[cyc]));
      if (e_ctl[cyc][2])
         chk("data_in", 64'(bus.data_in), 64'(e_din[cyc]));
      if (e_ctl[cyc][1]) cur[0] = e_rdat[cyc];
      if (e_ctl[cyc][0]) cur[1] = e_rdat[cyc];
      chk("rdata_a", 64'(bus.rdata_a), 64'(cur[0]));
      chk("rdata_b", 64'(bus.rdata_b), 64'(cur[1]));
      for (int r = 0; r < 2; r++) begin
         if (rnd && tq[r].size() == 0 && $urandom_range(0, 2) != 0)
            tq[r].push_back(mk(1'($urandom_range(0, 1)),
                               $urandom_range(0, 7), $urandom));
         if (e_ctl[cyc][5-r]) begin
            pend[r] = 1'b0;
            dwe[r]  = 1'($urandom_range(0, 1));
            dad[r]  = AW'($urandom);
            dwd[r]  = DW'($urandom);
         end
         if (!pend[r] && tq[r].size() != 0) begin
            t = tq[r].pop_front();
            pend[r] = 1'b1;
            {dwe[r], dad[r], dwd[r]} = t;
         end
      end
      apply();
      if (cyc >= free && (pend[0] || pend[1])) begin
         w = (pend[0] && pend[1]) ? ptr : (pend[1] ? 1 : 0);
         ptr = 1 - w;
         e_ctl[cyc+1][5-w] = 1'b1;
         e_addr[cyc+1] = dad[w];
         if (dwe[w]) begin
            e_ctl[cyc+1][2] = 1'b1;
            e_din[cyc+1] = dwd[w];
            ref_mem[dad[w]] = dwd[w];
            free = cyc + 2;
         end else begin
            e_ctl[cyc+1][3] = 1'b1;
            e_ctl[cyc+3][1-w] = 1'b1;
            e_rdat[cyc+3] = ref_mem[dad[w]];
            free = cyc + 3;
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      while ((tq[0].size() != 0 || tq[1].size() != 0 || pend[0] ||
              pend[1] || cyc <= free) && n < LIM) begin
         tick();
         n++;
      end
      chk("drain_budget", 64'(n >= LIM), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ = 1'b0;
      rnd  = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      for (int r = 0; r < 2; r++) begin
         dwe[r] = 1'b0;
         dad[r] = '0;
         dwd[r] = '0;
      end
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out", all_out(), 64'(0));
      @(posedge clk);
      #2 rst_ = 1'b1;

      // A alone: write then read back
      tq[0].push_back(mk(1'b1, 5'h03, 8'hA5));
      tq[0].push_back(mk(1'b0, 5'h03, 8'h00));
      drain();
      // read/write/read/write gaps
      tq[0].push_back(mk(1'b0, 5'h03, 8'h00));
      tq[0].push_back(mk(1'b1, 5'h04, 8'h11));
      tq[0].push_back(mk(1'b0, 5'h04, 8'h00));
      tq[0].push_back(mk(1'b1, 5'h05, 8'h22));
      drain();
      // both held continuously
      for (int i = 0; i < 4; i++) begin
         tq[0].push_back(mk(1'(i % 2), 8 + i, 16 * i + 1));
         tq[1].push_back(mk(1'((i + 1) % 2), 8 + i, 16 * i + 2));
      end
      drain();

      rnd = 1'b1;
      repeat (500) tick();
      rnd = 1'b0;
      drain();

      // reset in the middle of RDATA
      tq[0].push_back(mk(1'b0, 5'h03, 8'h00));
      tick();
      tick();
      @(negedge clk);
      rst_ = 1'b0;
      #1;
      chk("reset_async", all_out(), 64'(0));
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #2 rst_ = 1'b1;

      tq[0].push_back(mk(1'b1, 5'h06, 8'h5A));
      tq[1].push_back(mk(1'b1, 5'h07, 8'hC3));
      tq[1].push_back(mk(1'b0, 5'h06, 8'h00));
      tq[0].push_back(mk(1'b0, 5'h07, 8'h00));
      drain();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 5, giving the memory address width.
REQ-002 The block SHALL have the parameter DATA_W, default 8, giving the memory data width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_, input, 1, SHALL be an asynchronous, active-low reset.
REQ-005 Ports req_a/req_b, input, 1 each, SHALL be the access requests from requesters A/B; each is held high until that requester's grant.
REQ-006 Ports we_a/we_b, input, 1 each, SHALL select the access type: 1 = write, 0 = read.
REQ-007 Ports addr_a/addr_b, input, ADDR_W each, SHALL carry the requester addresses.
REQ-008 Ports wdata_a/wdata_b, input, DATA_W each, SHALL carry the requester write data.
REQ-009 Ports gnt_a/gnt_b, output, 1 each, SHALL be one-cycle registered grant pulses.
REQ-010 Ports rvalid_a/rvalid_b, output, 1 each, SHALL be one-cycle read-data-valid pulses.
REQ-011 Ports rdata_a/rdata_b, output, DATA_W each, SHALL carry the read data returned to A/B.
REQ-012 Ports read/write, output, 1 each, SHALL be the memory read and write strobes.
REQ-013 Port addr, output, ADDR_W, SHALL be the memory address.
REQ-014 Port data_in, output, DATA_W, SHALL be the data written to memory.
REQ-015 Port data_out, input, DATA_W, SHALL be the memory read data, registered by the memory on the clk edge at which read is high.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RDATA.
REQ-017 IDLE with no request: the FSM SHALL remain in IDLE, with all strobes and pulses at 0.
REQ-018 IDLE with at least one request: the FSM SHALL select a winner, latch its we/addr/wdata and owner ID, pulse the winner's gnt in the following cycle, and go to ACCESS.
REQ-019 If only one requester is active, that requester SHALL win.
REQ-020 If both requesters are active, the requester selected by the round-robin pointer SHALL win.
REQ-021 On every grant, the pointer SHALL move to the non-winning requester.
REQ-022 In ACCESS, addr SHALL equal the latched address, and exactly one of write (latched we = 1) or read (latched we = 0) SHALL be high for exactly one cycle.
REQ-023 In ACCESS, data_in SHALL equal the latched wdata; outside ACCESS, data_in is don't-care.
REQ-024 From ACCESS, the FSM SHALL go to IDLE if the access is a write, and to RDATA if it is a read.
REQ-025 In RDATA, the block SHALL capture data_out into the owner's rdata register at the RDATA-ending edge.
REQ-026 rvalid of the owner SHALL be high in the cycle after RDATA, with rdata stable from that cycle until the owner's next read completes; the FSM SHALL go to IDLE.
REQ-027 Latency SHALL be: gnt one cycle after acceptance; write strobe in the grant cycle; rvalid three cycles after acceptance.
REQ-028 Throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-029 A request's we/addr/wdata SHALL be sampled only at the IDLE->ACCESS edge; changes after that edge SHALL have no effect on the access in progress.
REQ-030 The requester of an access SHALL deassert req at the edge following its gnt; a req still high in IDLE SHALL be treated as a new request.
REQ-031 gnt_a and gnt_b SHALL never be high together, and neither SHALL be high in two consecutive cycles.
REQ-032 read and write SHALL never be high together.
REQ-033 rvalid_a and rvalid_b SHALL never be high together.
REQ-034 rvalid SHALL never be asserted for a write access.
REQ-035 The pointer SHALL not advance when no grant is issued.

Reset
REQ-036 While rst_ = 0, the FSM SHALL be in IDLE and the pointer SHALL select A.
REQ-037 While rst_ = 0, gnt_*, rvalid_*, read and write SHALL be 0, and rdata_*, addr and data_in SHALL be 0, all immediately and without waiting for clk.
REQ-038 Reset asserted during ACCESS or RDATA SHALL abort the access, with no rvalid issued afterwards; an aborted write may or may not have reached memory.
REQ-039 After rst_ deasserts, the block SHALL accept a request at the first rising edge of clk.

Verification
REQ-040 A alone writes addr 5'h03, data 8'hA5 -> gnt_a at +1, write = 1 with addr 03 and data_in A5 in the same cycle, no rvalid.
REQ-041 A reads addr 03 after the write above; the memory returns data_out = A5 -> rvalid_a = 1 with rdata_a = A5 at +3, and rvalid_b stays 0.
REQ-042 A and B request in the same cycle after reset -> A granted first, B granted in the next IDLE.
REQ-043 Both requesters hold req continuously -> grants alternate A, B, A, B.
REQ-044 Read, write, read, write in sequence -> gaps of exactly 3, 2, 3 cycles between grants.
REQ-045 rst_ pulled low mid-RDATA -> all outputs 0 immediately, no rvalid afterwards, and the next request is served normally with the pointer back at A.
